// File: rtl/ides8_pkg.sv
// Shared definitions for the IDES8 word-alignment controller.
package ides8_pkg;

  localparam int unsigned IDES8_RATIO     = 8;
  localparam logic [7:0]  DEFAULT_PATTERN = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } lane_state_e;

  function automatic logic lane_active(input lane_state_e s);
    return (s == ST_CHECK) || (s == ST_SLIP) || (s == ST_SETTLE);
  endfunction

endpackage

// File: rtl/ides8_lane_align.sv
// Single-lane bitslip FSM: pulses CALIB until the word matches the training
// pattern MATCHES times in a row, or gives up after all 8 positions.
module ides8_lane_align
  import ides8_pkg::*;
#(
  parameter logic [7:0]  PATTERN = DEFAULT_PATTERN,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned MATCHES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [IDES8_RATIO-1:0] word_i,
  output logic                   calib_o,
  output logic                   locked_o,
  output logic                   fail_o,
  output logic                   busy_o,
  output logic [2:0]             slips_o
);

  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned MW = $clog2(MATCHES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCHES - 1);
  localparam logic [MW-1:0] MATCH_MAX   = MW'(MATCHES);

  lane_state_e   state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [MW-1:0] match_q, match_d;
  logic [2:0]    slips_q, slips_d;
  logic          calib_q, locked_q, fail_q, busy_q;

  // Next-state and counter update for the alignment sequence.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    slips_d  = slips_q;
    case (state_q)
      ST_IDLE, ST_LOCKED, ST_FAIL: begin
        if (start_i) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
          match_d  = '0;
          slips_d  = 3'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
          match_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_CHECK: begin
        if (word_i == PATTERN) begin
          if (match_q == MATCH_LAST) begin
            match_d = MATCH_MAX;
            state_d = ST_LOCKED;
          end else begin
            match_d = match_q + MW'(1);
          end
        end else begin
          match_d = '0;
          // slips==7 means the eighth and last bit position was just rejected
          if (slips_q == 3'd7) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_SLIP;
            slips_d = slips_q + 3'd1;
          end
        end
      end
      ST_SLIP: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      match_q  <= '0;
      slips_q  <= 3'd0;
      calib_q  <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      slips_q  <= slips_d;
      calib_q  <= (state_d == ST_SLIP);
      locked_q <= (state_q == ST_LOCKED);
      fail_q   <= (state_q == ST_FAIL);
      busy_q   <= lane_active(state_q);
    end
  end

  assign calib_o  = calib_q;
  assign locked_o = locked_q;
  assign fail_o   = fail_q;
  assign busy_o   = busy_q;
  assign slips_o  = slips_q;

endmodule

// File: rtl/ides8_align_ctrl.sv
// Bank-level bitslip controller: one alignment FSM per IDES8 lane, shared
// start gating, aggregate busy and an end-of-run done pulse.
module ides8_align_ctrl
  import ides8_pkg::*;
#(
  parameter int unsigned LANES   = 3,
  parameter logic [7:0]  PATTERN = DEFAULT_PATTERN,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned MATCHES = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [LANES*IDES8_RATIO-1:0]   data_i,
  output logic [LANES-1:0]               calib_o,
  output logic [LANES-1:0]               locked_o,
  output logic [LANES-1:0]               fail_o,
  output logic [LANES*3-1:0]             slips_o,
  output logic                           busy_o,
  output logic                           done_o
);

  logic             start_s;
  logic             busy_s;
  logic [LANES-1:0] lane_busy_s;
  logic             busy_dly_q;
  logic             done_q;

  // A start seen while any lane is still aligning is dropped, not queued.
  assign start_s = start_i & ~busy_s;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ides8_lane_align #(
      .PATTERN (PATTERN),
      .SETTLE  (SETTLE),
      .MATCHES (MATCHES)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start_i  (start_s),
      .word_i   (data_i[IDES8_RATIO*g +: IDES8_RATIO]),
      .calib_o  (calib_o[g]),
      .locked_o (locked_o[g]),
      .fail_o   (fail_o[g]),
      .busy_o   (lane_busy_s[g]),
      .slips_o  (slips_o[3*g +: 3])
    );
  end

  assign busy_s = |lane_busy_s;

  // Falling-edge detect of busy; the delay register is cleared by reset so
  // abandoning a run never produces a done pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_dly_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      busy_dly_q <= busy_s;
      done_q     <= busy_dly_q & ~busy_s;
    end
  end

  assign busy_o = busy_s;
  assign done_o = done_q;

endmodule

// File: tb/tb_ides8_align_ctrl.sv
// Self-checking bench for ides8_align_ctrl: a per-lane IDES8 model reacts to
// CALIB pulses; outcomes are predicted by searching slip positions directly.
module tb_ides8_align_ctrl;

  localparam int         LANES   = 3;
  localparam int         SETTLE  = 4;
  localparam int         MATCHES = 16;
  localparam logic [7:0] PAT     = 8'hF0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [23:0]      data;
  logic [2:0]       calib, locked, fail;
  logic [8:0]       slips;
  logic             busy, done;

  always #5 clk = ~clk;

  ides8_align_ctrl #(
    .LANES(LANES), .PATTERN(PAT), .SETTLE(SETTLE), .MATCHES(MATCHES)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_i(data),
    .calib_o(calib), .locked_o(locked), .fail_o(fail), .slips_o(slips),
    .busy_o(busy), .done_o(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane model: constant byte, or pattern rotated by (offset - pulses seen).
  logic       lane_const [LANES];
  logic [7:0] lane_byte  [LANES];
  int         lane_off   [LANES];
  int         cal_base   [LANES];
  int         cal_cnt    [LANES] = '{0, 0, 0};
  int         last_pulse [LANES] = '{-1000, -1000, -1000};
  logic       calib_prev [LANES] = '{1'b0, 1'b0, 1'b0};
  int         done_cnt = 0;
  int         cyc = 0;
  logic       glitch;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int r);
    logic [15:0] t;
    t = {v, v} >> (8 - r);
    return t[7:0];
  endfunction

  function automatic logic [7:0] model_word(input logic c, input logic [7:0] b,
                                            input int off, input int k);
    if (c) return b;
    return rotl8(PAT, ((off - k) % 8 + 8) % 8);
  endfunction

  always_comb begin
    data = 24'h0;
    for (int l = 0; l < LANES; l++)
      data[8*l +: 8] = model_word(lane_const[l], lane_byte[l], lane_off[l],
                                  cal_cnt[l] - cal_base[l]);
    if (glitch) data[7:0] = 8'h00;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    for (int l = 0; l < LANES; l++) begin
      calib_prev[l] <= calib[l];
      if (calib[l] === 1'b1) begin
        cal_cnt[l]    <= cal_cnt[l] + 1;
        last_pulse[l] <= cyc;
        chk("calib_width", 32'(calib_prev[l]), 32'd0);
        chk("calib_gap_ok", 32'(cyc - last_pulse[l] >= SETTLE + 2), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic start_run();
    for (int l = 0; l < LANES; l++) cal_base[l] = cal_cnt[l];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < 1000) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (3) tick();
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic predict(output logic [2:0] el, output logic [2:0] ef, output logic [8:0] es);
    for (int l = 0; l < LANES; l++) begin
      el[l] = 1'b0;
      ef[l] = 1'b1;
      es[3*l +: 3] = 3'd7;
      for (int k = 7; k >= 0; k--) begin
        if (model_word(lane_const[l], lane_byte[l], lane_off[l], k) == PAT) begin
          el[l] = 1'b1;
          ef[l] = 1'b0;
          es[3*l +: 3] = 3'(k);
        end
      end
    end
  endtask

  task automatic check_lanes(input string tag, input logic [2:0] el,
                             input logic [2:0] ef, input logic [8:0] es);
    chk({tag, "_locked"}, 32'(locked), 32'(el));
    chk({tag, "_fail"},   32'(fail),   32'(ef));
    chk({tag, "_slips"},  32'(slips),  32'(es));
    chk({tag, "_busy"},   32'(busy),   32'd0);
    for (int l = 0; l < LANES; l++)
      chk({tag, "_pulses"}, 32'(cal_cnt[l] - cal_base[l]), 32'(es[3*l +: 3]));
  endtask

  task automatic set_lane(input int l, input logic c, input logic [7:0] b, input int off);
    lane_const[l] = c;
    lane_byte[l]  = b;
    lane_off[l]   = off;
  endtask

  logic [2:0] el, ef;
  logic [8:0] es;
  int         k;
  int         d0;

  initial begin
    glitch = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      set_lane(l, 1'b0, 8'h00, 0);
      cal_base[l] = 0;
    end

    // Reset with start held high: reset wins
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_calib", 32'(calib), 32'd0);
    end
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_fail",   32'(fail),   32'd0);
    chk("rst_slips",  32'(slips),  32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk("post_rst_calib", 32'(calib), 32'd0);
    chk("post_rst_busy",  32'(busy),  32'd0);

    // Aligned input: exact lock latency, no slips
    start_run();
    k = 0;
    while (locked !== 3'b111 && k < 100) begin
      tick();
      k++;
    end
    chk("aligned_lock_latency", 32'(k), 32'(1 + SETTLE + MATCHES));
    wait_done("aligned");
    check_lanes("aligned", 3'b111, 3'b000, 9'd0);

    // Rotated lanes 0/3/7
    set_lane(0, 1'b0, 8'h00, 0);
    set_lane(1, 1'b0, 8'h00, 3);
    set_lane(2, 1'b0, 8'h00, 7);
    start_run();
    wait_done("rotated");
    predict(el, ef, es);
    check_lanes("rotated", el, ef, es);
    chk("rotated_slips_fixed", 32'(slips), 32'({3'd7, 3'd3, 3'd0}));

    // Garbage on lane 1
    set_lane(0, 1'b0, 8'h00, $urandom_range(0, 7));
    set_lane(1, 1'b1, 8'h55, 0);
    set_lane(2, 1'b0, 8'h00, $urandom_range(0, 7));
    start_run();
    wait_done("garbage");
    predict(el, ef, es);
    check_lanes("garbage", el, ef, es);
    chk("garbage_fail_vec", 32'(fail), 32'd2);

    // One-word glitch after 10 matches; start re-pulses while busy
    for (int l = 0; l < LANES; l++) set_lane(l, 1'b1, PAT, 0);
    start_run();
    for (int i = 1; i <= 30; i++) begin
      start  = (i == 8) || (i == 25);
      glitch = (i == 1 + SETTLE + 10);
      tick();
    end
    start  = 1'b0;
    glitch = 1'b0;
    chk("busy_start_dropped", 32'(locked[2:1]), 32'd3);
    wait_done("glitch");
    check_lanes("glitch", 3'b111, 3'b000, 9'b000_000_001);

    // Mid-run reset while lane 0 settles after its second slip
    set_lane(0, 1'b0, 8'h00, 3);
    set_lane(1, 1'b0, 8'h00, 0);
    set_lane(2, 1'b0, 8'h00, 0);
    start_run();
    k = 0;
    while (cal_cnt[0] - cal_base[0] < 2 && k < 200) begin
      tick();
      k++;
    end
    chk("midrst_two_slips", 32'(cal_cnt[0] - cal_base[0]), 32'd2);
    tick();
    d0 = done_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_calib",  32'(calib),  32'd0);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_slips",  32'(slips),  32'd0);
    chk("midrst_busy",   32'(busy),   32'd0);
    tick();
    chk("midrst_calib_after", 32'(calib), 32'd0);
    repeat (3) tick();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    // The deserialiser keeps its two slips across our reset
    set_lane(0, 1'b0, 8'h00, 1);
    start_run();
    chk("restart_slips_zero", 32'(slips), 32'd0);
    wait_done("restart");
    predict(el, ef, es);
    check_lanes("restart", el, ef, es);

    // Randomised runs
    for (int r = 0; r < 12; r++) begin
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(0, 3) == 0)
          set_lane(l, 1'b1, ($urandom_range(0, 2) == 0) ? PAT : 8'($urandom), 0);
        else
          set_lane(l, 1'b0, 8'h00, $urandom_range(0, 7));
      end
      start_run();
      wait_done("rand");
      predict(el, ef, es);
      check_lanes("rand", el, ef, es);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
